serial_select_subtractor: RTL and testbench



---
 rtl/serial_select_subtractor.sv | 177 +++++++++++++++++
 tb/tb_serial_select_subtractor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_select_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB digit first.
// Each slice forms both borrow-in results and the registered borrow selects one.
module serial_select_subtractor #(
   parameter int WIDTH      = 32,
   parameter int DIGIT      = 4,
   parameter int NUM_DIGITS = WIDTH / DIGIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int            CW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit DIGIT of the result is the borrow-out: a negative difference wraps it to 1.
   function automatic logic [DIGIT:0] digit_sub(
      input logic [DIGIT-1:0] x,
      input logic [DIGIT-1:0] y,
      input logic             bi
   );
      return {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [DIGIT:0]   sub0_s;
   logic [DIGIT:0]   sub1_s;
   logic [DIGIT:0]   sel_s;

   // Both borrow-in cases for the current low digit, then the borrow-driven select.
   always_comb begin
      sub0_s = digit_sub(a_q[DIGIT-1:0], b_q[DIGIT-1:0], 1'b0);
      sub1_s = digit_sub(a_q[DIGIT-1:0], b_q[DIGIT-1:0], 1'b1);
      if (borrow_q) begin
         sel_s = sub1_s;
      end else begin
         sel_s = sub0_s;
      end
   end

   // Next-state and datapath update; operands shift right so the active digit is always at bit 0.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      a_msb_d     = a_msb_q;
      b_msb_d     = b_msb_q;
      borrow_d    = borrow_q;
      count_d     = count_q;
      diff_d      = diff_q;
      bout_d      = bout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d        = a;
               b_d        = b;
               a_msb_d    = a[WIDTH-1];
               b_msb_d    = b[WIDTH-1];
               borrow_d   = bin;
               count_d    = {CW{1'b0}};
               in_ready_d = 1'b0;
               state_d    = RUN;
            end else begin
               in_ready_d = 1'b1;
            end
         end

         RUN: begin
            diff_d[int'(count_q) * DIGIT +: DIGIT] = sel_s[DIGIT-1:0];
            borrow_d = sel_s[DIGIT];
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            count_d  = count_q + CW'(1);
            if (count_q == LAST) begin
               bout_d      = sel_s[DIGIT];
               ovf_d       = (a_msb_q != b_msb_q) && (diff_d[WIDTH-1] != a_msb_q);
               zero_d      = (diff_d == {WIDTH{1'b0}});
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               state_d = RUN;
            end
         end

         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end else begin
               state_d = DONE;
            end
         end

         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State, datapath and registered handshake/result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= {WIDTH{1'b0}};
         b_q         <= {WIDTH{1'b0}};
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         borrow_q    <= 1'b0;
         count_q     <= {CW{1'b0}};
         diff_q      <= {WIDTH{1'b0}};
         bout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         a_msb_q     <= a_msb_d;
         b_msb_q     <= b_msb_d;
         borrow_q    <= borrow_d;
         count_q     <= count_d;
         diff_q      <= diff_d;
         bout_q      <= bout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_select_subtractor.sv
// Directed bench for serial_select_subtractor: vector table plus back-pressure and reset sequences.
module tb_serial_select_subtractor;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;
   logic         zero;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
      logic         zero;
   } vec_t;

   vec_t vecs[10];

   serial_select_subtractor #(.WIDTH(32), .DIGIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present operands, take the accepting edge, then scramble inputs.
   task automatic start_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bini);
      in_valid = 1'b1;
      a        = ai;
      b        = bi;
      bin      = bini;
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      a   = ~ai;
      b   = ~bi;
      bin = ~bini;
      chk("in_ready_after_accept", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_pop", 32'(out_valid), 32'd0);
      chk("in_ready_after_pop", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int           lat;
      logic [W-1:0] held;

      vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{32'h0000000F, 32'h00000001, 1'b1, 32'h0000000D, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{32'h00000010, 32'h00000001, 1'b0, 32'h0000000F, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h4B4B4B4B, 1'b0, 1'b1, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_diff", diff, 32'd0);
      chk("reset_flags", {29'd0, bout, ovf, zero}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
         in_valid = 1'b0;
         wait_done(lat);
         chk("latency", 32'(lat), 32'd8);
         chk("diff", diff, vecs[i].diff);
         chk("bout", 32'(bout), 32'(vecs[i].bout));
         chk("ovf", 32'(ovf), 32'(vecs[i].ovf));
         chk("zero", 32'(zero), 32'(vecs[i].zero));
         pop();
      end

      // Back-pressure with a competing request held on the input.
      start_op(32'h00000009, 32'h00000002, 1'b0);
      in_valid = 1'b0;
      wait_done(lat);
      chk("bp_latency", 32'(lat), 32'd8);
      held     = diff;
      chk("bp_diff", diff, 32'h00000007);
      in_valid = 1'b1;
      a        = 32'h00000064;
      b        = 32'h0000000A;
      bin      = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_diff_held", diff, held);
      end
      pop();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_second_accept", 32'(in_ready), 32'd0);
      wait_done(lat);
      chk("bp2_latency", 32'(lat), 32'd8);
      chk("bp2_diff", diff, 32'h0000005A);
      pop();

      // Reset during the fourth RUN cycle.
      start_op(32'h12345678, 32'h00000001, 1'b0);
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_diff", diff, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("midrst_no_valid", 32'(out_valid), 32'd0);
      end
      start_op(32'd10, 32'd4, 1'b0);
      in_valid = 1'b0;
      wait_done(lat);
      chk("post_rst_latency", 32'(lat), 32'd8);
      chk("post_rst_diff", diff, 32'd6);
      chk("post_rst_flags", {29'd0, bout, ovf, zero}, 32'd0);
      pop();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
